// File: rtl/clock_div_multi.sv
// Multi-channel programmable divider: per-channel period/high-time, glitch-free config apply.
// Optional macro CLOCK_DIV_MULTI_PHASE_EN adds phase_in for phase-offset restart on sync.
module clock_div_multi #(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned RESET_PERIOD = 2,
    parameter int unsigned RESET_HIGH   = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CHANNELS-1:0]           enable,
    input  logic [CHANNELS-1:0]           load,
    input  logic [CHANNELS*CNT_WIDTH-1:0] period_in,
    input  logic [CHANNELS*CNT_WIDTH-1:0] high_in,
`ifdef CLOCK_DIV_MULTI_PHASE_EN
    input  logic [CHANNELS*CNT_WIDTH-1:0] phase_in,
`endif
    input  logic                          sync,
    output logic [CHANNELS-1:0]           cfg_pending,
    output logic [CHANNELS-1:0]           div_clk,
    output logic [CHANNELS-1:0]           pos_change,
    output logic [CHANNELS-1:0]           neg_change
);

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        cnt_t cnt_q, cnt_d;
        cnt_t per_q, per_d;
        cnt_t high_q, high_d;
        cnt_t pend_per_q, pend_per_d;
        cnt_t pend_high_q, pend_high_d;
        cnt_t eff_per, eff_high, phase;
        logic pend_v_q, pend_v_d;
        logic level_q, level_d;
        logic was_en_q;
        logic wrap, restart, apply;

        always_comb begin
            wrap    = (per_q != '0) && (cnt_q == per_q - 1'b1);
            // Restart at phase 0 on sync or on the first cycle after a disable.
            restart = enable[i] && (sync || !was_en_q);
            apply   = pend_v_q && (!enable[i] || (per_q == '0) || wrap || restart);

            eff_per  = apply ? pend_per_q : per_q;
            eff_high = apply ? pend_high_q : high_q;

`ifdef CLOCK_DIV_MULTI_PHASE_EN
            phase = (sync && (phase_in[i*CNT_WIDTH +: CNT_WIDTH] < eff_per))
                    ? phase_in[i*CNT_WIDTH +: CNT_WIDTH] : '0;
`else
            phase = '0;
`endif

            if (!enable[i]) begin
                cnt_d = '0;
            end else if (restart) begin
                cnt_d = phase;
            end else if ((per_q == '0) || wrap) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end

            level_d = enable[i] && (eff_per != '0) && (cnt_d < eff_high);
            per_d   = eff_per;
            high_d  = eff_high;

            pend_per_d  = pend_per_q;
            pend_high_d = pend_high_q;
            if (load[i]) begin
                pend_per_d  = period_in[i*CNT_WIDTH +: CNT_WIDTH];
                pend_high_d = high_in[i*CNT_WIDTH +: CNT_WIDTH];
            end
            // A load coinciding with apply stays pending for the next boundary.
            pend_v_d = load[i] || (pend_v_q && !apply);
        end

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                cnt_q       <= '0;
                per_q       <= CNT_WIDTH'(RESET_PERIOD);
                high_q      <= CNT_WIDTH'(RESET_HIGH);
                pend_per_q  <= '0;
                pend_high_q <= '0;
                pend_v_q    <= 1'b0;
                level_q     <= 1'b0;
                was_en_q    <= 1'b1;
            end else begin
                cnt_q       <= cnt_d;
                per_q       <= per_d;
                high_q      <= high_d;
                pend_per_q  <= pend_per_d;
                pend_high_q <= pend_high_d;
                pend_v_q    <= pend_v_d;
                level_q     <= level_d;
                was_en_q    <= enable[i];
            end
        end

        assign div_clk[i]     = level_q;
        assign cfg_pending[i] = pend_v_q;
        assign pos_change[i]  = reset & ~level_q & level_d;
        assign neg_change[i]  = reset & level_q & ~level_d;
    end

endmodule

// File: tb/tb_clock_div_multi.sv
// Scoreboard bench for clock_div_multi: stimulus queues expected per-channel outputs,
// a negedge monitor pops and compares them.
module tb_clock_div_multi;
    localparam int CH = 4;
    localparam int W  = 16;

    logic              clock  = 1'b0;
    logic              reset  = 1'b1;
    logic [CH-1:0]     enable = '0;
    logic [CH-1:0]     load   = '0;
    logic [CH*W-1:0]   period_in = '0;
    logic [CH*W-1:0]   high_in   = '0;
    logic              sync   = 1'b0;
    logic [CH-1:0]     cfg_pending, div_clk, pos_change, neg_change;
`ifdef CLOCK_DIV_MULTI_PHASE_EN
    logic [CH*W-1:0]   phase_in = '0;
`endif

    clock_div_multi #(
        .CHANNELS(CH), .CNT_WIDTH(W), .RESET_PERIOD(2), .RESET_HIGH(1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .period_in   (period_in),
        .high_in     (high_in),
`ifdef CLOCK_DIV_MULTI_PHASE_EN
        .phase_in    (phase_in),
`endif
        .sync        (sync),
        .cfg_pending (cfg_pending),
        .div_clk     (div_clk),
        .pos_change  (pos_change),
        .neg_change  (neg_change)
    );

    always #5 clock = ~clock;

    typedef struct {
        string tag;
        int    ch;
        bit    d, p, n, c;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(string tag, string field, logic act, logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s %s: got %b, required %b (t=%0t)", tag, field, act, req, $time);
        end
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk(e.tag, $sformatf("div_clk[%0d]", e.ch), div_clk[e.ch], e.d);
            chk(e.tag, $sformatf("pos_change[%0d]", e.ch), pos_change[e.ch], e.p);
            chk(e.tag, $sformatf("neg_change[%0d]", e.ch), neg_change[e.ch], e.n);
            chk(e.tag, $sformatf("cfg_pending[%0d]", e.ch), cfg_pending[e.ch], e.c);
        end
    end

    task automatic expect_ch(string tag, int ch, bit d, bit p, bit n, bit c);
        exp_t e;
        e.tag = tag; e.ch = ch; e.d = d; e.p = p; e.n = n; e.c = c;
        q.push_back(e);
    endtask

    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic cfg(int ch, int per, int high);
        period_in[ch*W +: W] = W'(per);
        high_in[ch*W +: W]   = W'(high);
    endtask

    task automatic do_reset(logic [CH-1:0] en);
        reset = 1'b0; enable = '0; load = '0; sync = 1'b0;
        next();
        next();
        reset  = 1'b1;
        enable = en;
    endtask

    // Default P=2,H=1 sequence after reset release: k=0 idle, then alternating rise/fall.
    task automatic default_cycle(string tag, int ch, int k);
        if (k == 0)          expect_ch(tag, ch, 0, 0, 0, 0);
        else if (k % 2 == 1) expect_ch(tag, ch, 0, 1, 0, 0);
        else                 expect_ch(tag, ch, 1, 0, 1, 0);
    endtask

    initial begin : stim
        #1 reset = 1'b0;
        enable = '1;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < CH; c++) expect_ch("in_reset", c, 0, 0, 0, 0);
            next();
        end

        // Release with all channels enabled, reset config.
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            for (int c = 0; c < CH; c++) default_cycle("default", c, k);
            next();
        end

        // ch0 loads P=5,H=2 mid-period.
        cfg(0, 5, 2); load = 4'b0001;
        expect_ch("ld5_k6", 0, 1, 0, 1, 0); next();
        load = '0;
        expect_ch("ld5_wrap", 0, 0, 1, 0, 1); next();
        expect_ch("ld5_k8", 0, 1, 0, 0, 0); next();
        expect_ch("ld5_k9", 0, 1, 0, 1, 0); next();
        expect_ch("ld5_k10", 0, 0, 0, 0, 0); next();
        expect_ch("ld5_k11", 0, 0, 0, 0, 0); next();
        expect_ch("ld5_k12", 0, 0, 1, 0, 0); next();
        expect_ch("ld5_k13", 0, 1, 0, 0, 0); next();
        expect_ch("ld5_k14", 0, 1, 0, 1, 0); next();

        // ch1: P=4,H=0 (constant low), then H=7 (constant high).
        do_reset(4'b0010);
        cfg(1, 4, 0); load = 4'b0010;
        expect_ch("h0_r0", 1, 0, 0, 0, 0); next();
        load = '0;
        expect_ch("h0_apply", 1, 0, 0, 0, 1); next();
        expect_ch("h0_r2", 1, 0, 0, 0, 0); next();
        cfg(1, 4, 7); load = 4'b0010;
        expect_ch("h0_r3", 1, 0, 0, 0, 0); next();
        load = '0;
        expect_ch("h7_pend", 1, 0, 0, 0, 1); next();
        expect_ch("h7_apply", 1, 0, 1, 0, 1); next();
        for (int k = 0; k < 5; k++) begin
            expect_ch("h7_const", 1, 1, 0, 0, 0); next();
        end

        // ch2: disable while high, then re-enable.
        do_reset(4'b0100);
        for (int k = 0; k < 4; k++) begin
            default_cycle("dis_pre", 2, k); next();
        end
        enable = '0;
        expect_ch("dis_fall", 2, 1, 0, 1, 0); next();
        expect_ch("dis_idle", 2, 0, 0, 0, 0); next();
        expect_ch("dis_idle", 2, 0, 0, 0, 0); next();
        enable = 4'b0100;
        expect_ch("reen_rise", 2, 0, 1, 0, 0); next();
        expect_ch("reen_fall", 2, 1, 0, 1, 0); next();
        expect_ch("reen_rise2", 2, 0, 1, 0, 0); next();

        // ch0/ch1 P=8,H=4 enabled at different times, then sync aligns them.
        do_reset(4'b0000);
        cfg(0, 8, 4); cfg(1, 8, 4); load = 4'b0011;
        expect_ch("sy_r0", 0, 0, 0, 0, 0); expect_ch("sy_r0", 1, 0, 0, 0, 0); next();
        load = '0;
        expect_ch("sy_r1", 0, 0, 0, 0, 1); expect_ch("sy_r1", 1, 0, 0, 0, 1); next();
        enable = 4'b0001;
        expect_ch("sy_r2", 0, 0, 1, 0, 0); expect_ch("sy_r2", 1, 0, 0, 0, 0); next();
        enable = 4'b0011;
        expect_ch("sy_r3", 0, 1, 0, 0, 0); expect_ch("sy_r3", 1, 0, 1, 0, 0); next();
        expect_ch("sy_r4", 0, 1, 0, 0, 0); expect_ch("sy_r4", 1, 1, 0, 0, 0); next();
        sync = 1'b1;
        expect_ch("sy_s", 0, 1, 0, 0, 0); expect_ch("sy_s", 1, 1, 0, 0, 0); next();
        sync = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            bit d, p, n;
            d = (j <= 4) || (j == 9);
            p = (j == 8);
            n = (j == 4);
            expect_ch("sy_after", 0, d, p, n, 0);
            expect_ch("sy_after", 1, d, p, n, 0);
            next();
        end

        // ch3: reset while a load is pending discards it.
        do_reset(4'b1000);
        expect_ch("rp_r0", 3, 0, 0, 0, 0); next();
        cfg(3, 5, 2); load = 4'b1000;
        expect_ch("rp_r1", 3, 0, 1, 0, 0); next();
        load = '0;
        expect_ch("rp_pend", 3, 1, 0, 1, 1); next();
        reset = 1'b0;
        expect_ch("rp_in_reset", 3, 0, 0, 0, 0); next();
        expect_ch("rp_in_reset", 3, 0, 0, 0, 0); next();
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            default_cycle("rp_after", 3, k); next();
        end

        for (int k = 0; k < 5 && q.size() > 0; k++) next();
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
